ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 104 ++++++++++
 tb/tb_ifetch_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ============================================================================
// Module      : ifetch_queue
// Description : Circular instruction queue between fetch and decode, with
//               flush and asynchronous reset.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

typedef enum logic [1:0] {
  NOERROR      = 2'd0,
  ACCESS_FAULT = 2'd1,
  PAGE_FAULT   = 2'd2,
  MISALIGNED   = 2'd3
} fetch_err_t;

typedef struct packed {
  logic        valid;
  logic [31:0] raw_instr;
  logic [63:0] pc;
  fetch_err_t  error;
} fetch_data_t;

module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  fetch_data_t              dataF,
  input  logic                     deq_ready,
  input  logic                     flush,
  output fetch_data_t              dataQ,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    fetch_err_t  error;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_CNT_W-1:0]   r_count;
  logic                 w_empty;
  logic                 w_enq;
  logic                 w_deq;
  entry_t               w_head_entry;

  // full comes from registered occupancy only, so a same-cycle dequeue never frees a slot early
  assign w_empty = (r_count == '0);
  assign full    = (r_count == c_DEPTH_CNT);
  assign w_enq   = dataF.valid && !full && !flush;
  assign w_deq   = !w_empty && deq_ready && !flush;
  assign count   = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + c_PTR_W'(1);
      if (w_deq) r_head <= r_head + c_PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; empty slots are hidden by the output mask below
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= '{raw_instr: dataF.raw_instr, pc: dataF.pc, error: dataF.error};
    end
  end

  assign w_head_entry = r_mem[r_head];

  always_comb begin
    dataQ       = '0;
    dataQ.error = NOERROR;
    if (!w_empty) begin
      dataQ.valid     = 1'b1;
      dataQ.raw_instr = w_head_entry.raw_instr;
      dataQ.pc        = w_head_entry.pc;
      dataQ.error     = w_head_entry.error;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Directed scoreboard bench for ifetch_queue (DEPTH=4).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   reset;
  fetch_data_t            dataF;
  logic                   deq_ready;
  logic                   flush;
  fetch_data_t            dataQ;
  logic                   full;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  fetch_data_t exp_q[$];
  fetch_data_t mon_exp;

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .dataF     (dataF),
    .deq_ready (deq_ready),
    .flush     (flush),
    .dataQ     (dataQ),
    .full      (full),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                       input fetch_err_t e, input logic expect_out);
    dataF = '{valid: v, raw_instr: instr, pc: pc, error: e};
    if (expect_out) exp_q.push_back(dataF);
  endtask

  task automatic idle_f();
    dataF = '0;
  endtask

  // Monitor: compares every head entry that actually leaves the queue
  always @(negedge clk) begin
    checks++;
    if (count > DEPTH || full !== (count == DEPTH)) begin
      errors++;
      $display("FAIL occupancy: count %0d full %0b", count, full);
    end
    if (!reset && !flush && deq_ready && dataQ.valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got pc %0h, none expected", dataQ.pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dataQ.pc !== mon_exp.pc || dataQ.raw_instr !== mon_exp.raw_instr ||
            dataQ.error !== mon_exp.error) begin
          errors++;
          $display("FAIL dequeue: got pc %0h instr %0h err %0d expected pc %0h instr %0h err %0d",
                   dataQ.pc, dataQ.raw_instr, dataQ.error,
                   mon_exp.pc, mon_exp.raw_instr, mon_exp.error);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    deq_ready = 1'b0;
    idle_f();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_valid", 64'(dataQ.valid), 64'd0);
    chk("reset_pc", dataQ.pc, 64'd0);
    chk("reset_instr", 64'(dataQ.raw_instr), 64'd0);
    chk("reset_err", 64'(dataQ.error), 64'(NOERROR));
    @(negedge clk);
    reset = 1'b0;
    step();

    // Dequeue on an empty queue is a no-op
    deq_ready = 1'b1;
    step();
    chk("empty_deq_count", 64'(count), 64'd0);

    // Single entry
    drive(1'b1, 32'h0000_0013, 64'h8000_0000, NOERROR, 1'b1);
    step();
    idle_f();
    chk("single_count", 64'(count), 64'd1);
    chk("single_valid", 64'(dataQ.valid), 64'd1);
    chk("single_pc", dataQ.pc, 64'h8000_0000);
    step();
    chk("single_drain_count", 64'(count), 64'd0);
    chk("single_drain_valid", 64'(dataQ.valid), 64'd0);

    // Fill to full, hold the 5th entry, then drain
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0010_0093 + 32'(i), 64'h8000_0000 + 64'(4 * i), NOERROR, 1'b1);
      step();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd4);
    drive(1'b1, 32'h0010_0097, 64'h8000_0010, NOERROR, 1'b1);
    step();
    chk("held_count", 64'(count), 64'd4);
    chk("held_head_pc", dataQ.pc, 64'h8000_0000);
    deq_ready = 1'b1;
    step();
    chk("full_deq_no_enq", 64'(count), 64'd3);
    chk("full_deq_full", 64'(full), 64'd0);
    step();
    idle_f();
    chk("held_accept_count", 64'(count), 64'd3);
    repeat (3) step();
    chk("fill_drain_count", 64'(count), 64'd0);

    // Back-to-back streaming across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0020_0013 + 32'(i), 64'h8000_0100 + 64'(4 * i), NOERROR, 1'b1);
      step();
      chk("stream_count", 64'(count), 64'd1);
    end
    idle_f();
    step();
    chk("stream_drain", 64'(count), 64'd0);

    // Flush with concurrent enqueue and dequeue
    deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0030_0013, 64'h8000_0200 + 64'(4 * i), NOERROR, 1'b0);
      step();
    end
    chk("preflush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h0030_0017, 64'h8000_020C, NOERROR, 1'b0);
    deq_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_f();
    deq_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(dataQ.valid), 64'd0);
    drive(1'b1, 32'h0040_0013, 64'h8000_0300, NOERROR, 1'b1);
    step();
    idle_f();
    chk("postflush_count", 64'(count), 64'd1);
    chk("postflush_pc", dataQ.pc, 64'h8000_0300);
    deq_ready = 1'b1;
    step();
    chk("postflush_drain", 64'(count), 64'd0);

    // Asynchronous reset between clock edges
    deq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0050_0013, 64'h8000_0400 + 64'(4 * i), NOERROR, 1'b0);
      step();
    end
    idle_f();
    chk("prereset_count", 64'(count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_count", 64'(count), 64'd0);
    chk("async_reset_full", 64'(full), 64'd0);
    chk("async_reset_valid", 64'(dataQ.valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h0000_0013, 64'h8000_0000, NOERROR, 1'b1);
    step();
    idle_f();
    chk("postreset_pc", dataQ.pc, 64'h8000_0000);
    chk("postreset_instr", 64'(dataQ.raw_instr), 64'h0000_0013);
    deq_ready = 1'b1;
    step();
    chk("postreset_drain", 64'(count), 64'd0);

    // Error passthrough
    deq_ready = 1'b0;
    drive(1'b1, 32'h0000_006F, 64'h8000_0020, PAGE_FAULT, 1'b1);
    step();
    idle_f();
    chk("err_field", 64'(dataQ.error), 64'(PAGE_FAULT));
    chk("err_pc", dataQ.pc, 64'h8000_0020);
    deq_ready = 1'b1;
    step();
    chk("err_drain", 64'(count), 64'd0);
    chk("err_empty_field", 64'(dataQ.error), 64'(NOERROR));

    step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
